// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one 4-bit logic unit (AND/OR/XOR/NOT) between two requesters.
// Latency: grant one cycle after req is sampled in IDLE, result valid one cycle after grant.
// Backpressure: result held in DONE until res_rdy; no new grant is issued until the result drains.

module lu_logic_unit (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic [1:0] op_i,
    output logic [3:0] res_o
);
    always_comb begin
        res_o = 4'b0000;
        unique case (op_i)
            2'b00:   res_o = x_i & y_i;
            2'b01:   res_o = x_i | y_i;
            2'b10:   res_o = x_i ^ y_i;
            default: res_o = ~x_i;
        endcase
    end
endmodule

module lu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [3:0]       x0,
    input  logic [3:0]       y0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [3:0]       x1,
    input  logic [3:0]       y1,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [3:0]       res,
    output logic             res_id,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             win_q, win_d;
    logic [3:0]       x_q, x_d;
    logic [3:0]       y_q, y_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       res_q, res_d;
    logic             res_id_q, res_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_vld;
    logic             grant_id;
    logic [3:0]       lu_res;

    // Under contention the pointer picks; otherwise whoever is asking wins.
    assign grant_vld = (state_q == S_IDLE) && (req0 || req1);
    assign grant_id  = (req0 && req1) ? ptr_q : req1;

    lu_logic_unit u_lu (
        .x_i   (x_q),
        .y_i   (y_q),
        .op_i  (op_q),
        .res_o (lu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  if (res_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt0    = (state_q == S_EXEC) && !win_q;
        gnt1    = (state_q == S_EXEC) &&  win_q;
        res_vld = (state_q == S_DONE);
        busy    = (state_q != S_IDLE);
    end

    always_comb begin
        ptr_d    = ptr_q;
        win_d    = win_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        cnt_d    = cnt_q;
        if (grant_vld) begin
            win_d = grant_id;
            ptr_d = !grant_id;
            x_d   = grant_id ? x1  : x0;
            y_d   = grant_id ? y1  : y0;
            op_d  = grant_id ? op1 : op0;
        end
        if (state_q == S_EXEC) begin
            res_d    = lu_res;
            res_id_d = win_q;
        end
        if ((state_q == S_DONE) && res_rdy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            x_q      <= 4'b0000;
            y_q      <= 4'b0000;
            op_q     <= 2'b00;
            res_q    <= 4'b0000;
            res_id_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign res    = res_q;
    assign res_id = res_id_q;
    assign op_cnt = cnt_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed plus randomized bench for lu_arbiter against a transaction-level reference model.
module tb_lu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] x0, y0, x1, y1;
    logic [1:0] op0, op1;
    logic       gnt0, gnt1;
    logic [3:0] res;
    logic       res_id, res_vld, res_rdy, busy;
    logic [1:0] op_cnt;

    int   errors = 0;
    int   checks = 0;
    logic m_ptr;
    int   m_cnt;

    always #5 clk = ~clk;

    lu_arbiter #(.CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .x0      (x0),
        .y0      (y0),
        .op0     (op0),
        .req1    (req1),
        .x1      (x1),
        .y1      (y1),
        .op1     (op1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .res     (res),
        .res_id  (res_id),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .busy    (busy),
        .op_cnt  (op_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_lu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_gnt0"},   8'(gnt0),    8'd0);
        check({pfx, "_gnt1"},   8'(gnt1),    8'd0);
        check({pfx, "_res"},    8'(res),     8'd0);
        check({pfx, "_res_id"}, 8'(res_id),  8'd0);
        check({pfx, "_vld"},    8'(res_vld), 8'd0);
        check({pfx, "_busy"},   8'(busy),    8'd0);
        check({pfx, "_cnt"},    8'(op_cnt),  8'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 0;
    endtask

    // One complete operation: grant, execute, optional stall in DONE, drain.
    task automatic txn(input logic r0, input logic r1,
                       input logic [3:0] ax0, input logic [3:0] ay0, input logic [1:0] aop0,
                       input logic [3:0] ax1, input logic [3:0] ay1, input logic [1:0] aop1,
                       input int stall, input bit scramble, input int exp_res);
        logic       w;
        logic [3:0] er;
        req0 = r0; req1 = r1;
        x0 = ax0; y0 = ay0; op0 = aop0;
        x1 = ax1; y1 = ay1; op1 = aop1;
        res_rdy = 1'b0;
        w  = (r0 && r1) ? m_ptr : r1;
        er = w ? model_lu(ax1, ay1, aop1) : model_lu(ax0, ay0, aop0);
        if (exp_res >= 0) er = 4'(exp_res);

        @(posedge clk); #1;
        check("gnt0",      8'(gnt0),    8'(!w));
        check("gnt1",      8'(gnt1),    8'(w));
        check("busy_exec", 8'(busy),    8'd1);
        check("vld_exec",  8'(res_vld), 8'd0);
        if (scramble) begin
            x0 = 4'b0000; y0 = 4'($urandom); op0 = 2'($urandom);
            x1 = 4'($urandom); y1 = 4'($urandom); op1 = 2'($urandom);
        end

        @(posedge clk); #1;
        check("vld",      8'(res_vld),     8'd1);
        check("res",      8'(res),         8'(er));
        check("res_id",   8'(res_id),      8'(w));
        check("gnt_done", 8'(gnt0 | gnt1), 8'd0);

        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_vld",  8'(res_vld),     8'd1);
            check("hold_res",  8'(res),         8'(er));
            check("hold_id",   8'(res_id),      8'(w));
            check("hold_gnt",  8'(gnt0 | gnt1), 8'd0);
            check("hold_busy", 8'(busy),        8'd1);
        end

        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        m_cnt = (m_cnt + 1) % 4;
        m_ptr = !w;
        check("vld_clr",  8'(res_vld), 8'd0);
        check("busy_idl", 8'(busy),    8'd0);
        check("op_cnt",   8'(op_cnt),  8'(m_cnt));
        check("res_keep", 8'(res),     8'(er));
        check("id_keep",  8'(res_id),  8'(w));
    endtask

    initial begin
        int exp1 [4];
        int r;
        exp1 = '{8, 15, 7, 4};
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; res_rdy = 1'b0;
        x0 = '0; y0 = '0; op0 = '0; x1 = '0; y1 = '0; op1 = '0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 0;

        // Idle with no request: nothing happens
        @(posedge clk); #1;
        check("idle_busy", 8'(busy), 8'd0);
        check("idle_gnt",  8'(gnt0 | gnt1), 8'd0);

        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b0, 4'b1011, 4'b1100, 2'(i), 4'd0, 4'd0, 2'd0, 0, 1'b0, exp1[i]);

        pulse_reset();
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 4'b1011, 4'b1100, 2'b00, 4'b0101, 4'b0011, 2'b10, 0, 1'b0,
                (i % 2 == 0) ? 8 : 6);

        txn(1'b1, 1'b1, 4'b1011, 4'b1100, 2'b00, 4'b0101, 4'b0011, 2'b10, 5, 1'b0, -1);

        txn(1'b1, 1'b0, 4'b1011, 4'b1100, 2'b00, 4'd0, 4'd0, 2'd0, 0, 1'b1, 8);

        // Abort an operation while it executes
        req0 = 1'b1; req1 = 1'b1;
        x0 = 4'b1111; y0 = 4'b1111; op0 = 2'b00;
        @(posedge clk); #1;
        check("pre_abort_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 0;
        txn(1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 4'b0110, 4'b1010, 2'b01, 0, 1'b0, 14);
        txn(1'b1, 1'b1, 4'b0011, 4'b0101, 2'b10, 4'b1111, 4'b0000, 2'b11, 0, 1'b0, 6);

        pulse_reset();
        for (int i = 0; i < 5; i++)
            txn(1'b1, 1'b0, 4'(i), 4'(~i), 2'b01, 4'd0, 4'd0, 2'd0, 0, 1'b0, 15);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(1, 3);
            txn(r[0], r[1], 4'($urandom), 4'($urandom), 2'($urandom),
                4'($urandom), 4'($urandom), 2'($urandom),
                $urandom_range(0, 3), 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lu_arbiter.md
Name: lu_arbiter

Overview:
Shares one 4-bit logic unit (AND/OR/XOR/NOT) between two requesters.
- Arbitrates with round-robin priority.
- Latches the winner's operands and operation, then runs them through one internal logic_unit instance.
- Presents a registered result under a valid/ready handshake, tagged with the winning requester's ID.
- Sits between two client blocks and the shared logical datapath; exactly one operation is in flight at a time.

Parameters:
CNT_W, 8, width of the completed-operation counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; held with x0/y0/op0 stable until gnt0 seen
x0  input  4  requester 0 operand x
y0  input  4  requester 0 operand y
op0  input  2  requester 0 operation: 00 AND, 01 OR, 10 XOR, 11 NOT x (op[1]=s1, op[0]=s0)
req1  input  1  requester 1 request
x1  input  4  requester 1 operand x
y1  input  4  requester 1 operand y
op1  input  2  requester 1 operation
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
res  output  4  registered result
res_id  output  1  requester that owns res
res_vld  output  1  result valid
res_rdy  input  1  consumer accepts result
busy  output  1  high whenever FSM not in IDLE
op_cnt  output  CNT_W  number of accepted results, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt0=gnt1=0, res=0, res_id=0, res_vld=0, op_cnt=0, priority pointer ptr=0 (requester 0 favoured). Reset mid-operation aborts it; the captured request is lost, and a requester still asserting req is re-arbitrated after release.
- FSM states: IDLE, EXEC, DONE. busy = (state != IDLE).
- IDLE:
  - No req: remain, outputs unchanged.
  - Only req0 (or only req1): grant that one.
  - Both: grant requester ptr.
  - On grant edge: capture x, y, op of the winner into internal registers; set gntN=1 for exactly one cycle; set ptr = ~winner; state to EXEC.
- EXEC:
  - Captured operands drive logic_unit combinationally.
  - At the edge: res=lu output, res_id=winner, res_vld=1, gnt cleared, state to DONE.
- DONE:
  - res, res_id and res_vld held stable while res_rdy=0.
  - At edge with res_rdy=1: res_vld=0, op_cnt+=1 (wrap at 2^CNT_W-1 to 0), state to IDLE. res and res_id retain their last value.
  - No new grant in the DONE cycle.
- Latency: req sampled at edge N, gnt high after N, res_vld high after N+1. Minimum 3 cycles per operation with res_rdy tied high.
- Requesters deassert req (or present a new op) after sampling gnt. req ignored outside IDLE. A req still high in IDLE is treated as a new request.
- Operand or op changes after the grant edge have no effect on the in-flight result.
- Results:
  - op=11 ignores y: res = ~x.
  - All outputs are 4-bit bitwise; no carry or overflow.
- gnt0 and gnt1 are never high simultaneously. res_vld and gnt are never high in the same cycle.

Test Plan:
1. Single requester, all ops: req0 only, x0=1011, y0=1100, op0=00/01/10/11 in turn, res_rdy=1 -> res=1000/1111/0111/0100, res_id=0, gnt0 pulses 1 cycle, res_vld 2 edges after req; op_cnt ends 4.
2. Contention round-robin: req0 and req1 held high, x1=0101, y1=0011, op1=10, requester 0 as in test 1 with op0=00 -> grants alternate gnt0, gnt1, gnt0, ...; results alternate 1000 (id 0) and 0110 (id 1); first grant to requester 0 after reset.
3. Back-pressure: res_rdy=0 for 5 cycles during DONE -> res, res_id and res_vld=1 stay stable; no gnt issued; busy=1. Raising res_rdy -> IDLE next cycle, op_cnt increments by exactly 1.
4. Operand change after grant: the cycle after gnt0, change x0 to 0000 -> result still computed from the captured 1011.
5. Reset mid-operation: assert rst_n=0 while in EXEC -> immediately res_vld=0, res=0, op_cnt=0, busy=0. After release with req1 held, requester 1 is granted; ptr is back to 0, so simultaneous requests favour requester 0.
6. Counter wrap: CNT_W=2, complete 5 operations -> op_cnt reads 1,2,3,0,1.
